// File: rtl/quant_mem_ctrl_if.sv
// Memory-side bus of the quantized frame controller: synchronous write port,
// combinational read port, plus the controller FSM state for observation.
interface quant_mem_ctrl_if #(
  parameter int AW = 12,
  parameter int DW = 6
);
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    ctrl_state;

  modport master (
    output mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_state,
    input  mem_rdata
  );

  modport slave (
    input  mem_we, mem_waddr, mem_wdata, mem_raddr, ctrl_state,
    output mem_rdata
  );
endinterface

// File: rtl/quant_mem_ctrl.sv
// Loads one frame of quantized samples into memory, then serves single
// outstanding feature reads with a fixed 2-cycle latency until released.
module quant_mem_ctrl #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int DW    = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          load_done,
  output logic          frame_valid,
  input  logic          frame_release,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_ready,
  output logic          rd_ack,
  output logic [DW-1:0] rd_data,
  output logic          rd_err,
  quant_mem_ctrl_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_waddr_q, mem_waddr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [AW-1:0] mem_raddr_q, mem_raddr_d;
  logic          rd_busy_q, rd_busy_d;
  logic          rd_ack_q, rd_ack_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;
  logic          load_done_q, load_done_d;
  logic          accept;
  logic          rd_accept;
  logic          last_entry;

  // Handshakes: a sample moves on in_valid & in_ready, a read on rd_req & rd_ready;
  // both ready signals depend only on registered state, never on the request.
  assign in_ready    = (state_q == S_LOAD);
  assign frame_valid = (state_q == S_VALID);
  assign rd_ready    = frame_valid & ~rd_busy_q;
  assign accept      = in_valid & in_ready;
  assign rd_accept   = rd_req & rd_ready;
  assign last_entry  = (wr_ptr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_raddr_d = mem_raddr_q;
    rd_busy_d   = 1'b0;
    rd_ack_d    = 1'b0;
    rd_data_d   = rd_data_q;
    rd_err_d    = rd_err_q;
    load_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d  = S_LOAD;
          wr_ptr_d = '0;
        end
      end
      S_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_waddr_d = wr_ptr_q;
          mem_wdata_d = in_data;
          if (last_entry) begin
            state_d     = S_VALID;
            wr_ptr_d    = '0;
            load_done_d = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
        end
      end
      S_VALID: begin
        // A release competing with an in-flight or newly accepted read waits.
        if (frame_release && !rd_busy_q && !rd_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_accept) begin
      mem_raddr_d = rd_addr;
      rd_busy_d   = 1'b1;
    end
    if (rd_busy_q) begin
      rd_data_d = mem.mem_rdata;
      rd_ack_d  = 1'b1;
    end
    if (rd_req && !frame_valid) begin
      rd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_raddr_q <= '0;
      rd_busy_q   <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      rd_err_q    <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_raddr_q <= mem_raddr_d;
      rd_busy_q   <= rd_busy_d;
      rd_ack_q    <= rd_ack_d;
      rd_data_q   <= rd_data_d;
      rd_err_q    <= rd_err_d;
      load_done_q <= load_done_d;
    end
  end

  assign load_done      = load_done_q;
  assign rd_ack         = rd_ack_q;
  assign rd_data        = rd_data_q;
  assign rd_err         = rd_err_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_waddr  = mem_waddr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign mem.mem_raddr  = mem_raddr_q;
  assign mem.ctrl_state = state_q;

endmodule
